// File: rtl/fetch_unit.sv
// Instruction fetch sequencer for the 4-bit CPU.
// Drives the ROM address, captures the registered ROM word one cycle later,
// splits it into opcode/operand and hands it to execute over valid/ready.
// A HALT opcode stops fetching until reset. Branch redirects from execute
// discard any in-flight or held instruction and restart fetch at the target.
module fetch_unit #(
    parameter int              ADDR_W   = 4,
    parameter int              INSTR_W  = 8,
    parameter int              OPC_W    = 4,
    parameter logic [OPC_W-1:0] HALT_OPC = 4'hF
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        pc_addr,
    input  logic [INSTR_W-1:0]       instruction_in,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [OPC_W-1:0]         opcode,
    output logic [INSTR_W-OPC_W-1:0] operand,
    input  logic                     branch_en,
    input  logic [ADDR_W-1:0]        branch_target,
    output logic                     halted
);

    localparam int OPR_W = INSTR_W - OPC_W;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DATA  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_valid;
    logic [OPC_W-1:0]   r_opcode;
    logic [OPR_W-1:0]   r_operand;
    logic               r_halted;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               w_valid_nxt;
    logic [OPC_W-1:0]   w_opcode_nxt;
    logic [OPR_W-1:0]   w_operand_nxt;
    logic               w_halted_nxt;
    logic               w_handshake;

    assign w_handshake = r_valid && instr_ready;

    // Next-state and next-output logic; a branch overrides the normal move.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_valid_nxt   = r_valid;
        w_opcode_nxt  = r_opcode;
        w_operand_nxt = r_operand;
        w_halted_nxt  = r_halted;

        case (r_state)
            // ROM samples pc_addr at this edge; its word is ready next cycle.
            S_FETCH: begin
                w_state_nxt = S_DATA;
            end
            // ROM word for r_pc is on instruction_in: latch it and advance pc.
            S_DATA: begin
                w_opcode_nxt  = instruction_in[INSTR_W-1 -: OPC_W];
                w_operand_nxt = instruction_in[OPR_W-1:0];
                w_pc_nxt      = r_pc + ADDR_W'(1);
                w_valid_nxt   = 1'b1;
                w_state_nxt   = S_HOLD;
            end
            // Present the instruction until execute takes it.
            S_HOLD: begin
                if (w_handshake) begin
                    w_valid_nxt = 1'b0;
                    if (r_opcode == HALT_OPC) begin
                        w_state_nxt  = S_HALT;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            // Terminal until reset: pc frozen, nothing presented.
            S_HALT: begin
                w_valid_nxt  = 1'b0;
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // Redirect wins over everything except HALT. Any word being captured
        // or held is dropped, so opcode/operand keep their old contents and a
        // same-cycle HALT handshake does not set halted.
        if (branch_en && (r_state != S_HALT)) begin
            w_state_nxt   = S_FETCH;
            w_pc_nxt      = branch_target;
            w_valid_nxt   = 1'b0;
            w_opcode_nxt  = r_opcode;
            w_operand_nxt = r_operand;
            w_halted_nxt  = r_halted;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_valid   <= w_valid_nxt;
            r_opcode  <= w_opcode_nxt;
            r_operand <= w_operand_nxt;
            r_halted  <= w_halted_nxt;
        end
    end

    assign pc_addr     = r_pc;
    assign instr_valid = r_valid;
    assign opcode      = r_opcode;
    assign operand     = r_operand;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural registered ROM, directed scenarios,
// and a scoreboard that checks every accepted instruction.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [3:0] pc_addr;
    logic [7:0] instruction_in;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       branch_en;
    logic [3:0] branch_target;
    logic       halted;

    logic [7:0] rom [16];

    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] opr;
        logic [3:0] pc;
    } exp_t;

    exp_t sbq[$];

    int checks;
    int errors;

    fetch_unit #(
        .ADDR_W  (4),
        .INSTR_W (8),
        .OPC_W   (4),
        .HALT_OPC(4'hF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .instruction_in(instruction_in),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .opcode        (opcode),
        .operand       (operand),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: word for the address sampled at an edge appears after it.
    always @(posedge clk) instruction_in <= rom[pc_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", {28'd0, pc_addr}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] w, input logic [3:0] pc_after);
        exp_t e;
        e.opc = w[7:4];
        e.opr = w[3:0];
        e.pc  = pc_after;
        sbq.push_back(e);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h52;
        rom[1] = 8'h57;
        rom[2] = 8'h81;
        rom[3] = 8'hF0;
    endtask

    // Monitor: every accepted instruction must match the next expected entry.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h%0h expected=none", opcode, operand);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_opcode", {28'd0, opcode}, {28'd0, e.opc});
                chk("sb_operand", {28'd0, operand}, {28'd0, e.opr});
                chk("sb_pc", {28'd0, pc_addr}, {28'd0, e.pc});
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        instr_ready   = 1'b0;
        branch_en     = 1'b0;
        branch_target = 4'd0;
        load_prog();

        // Initial reset state.
        tick(2);
        chk("init_valid", {31'd0, instr_valid}, 32'd0);
        chk("init_pc", {28'd0, pc_addr}, 32'd0);
        chk("init_opcode", {28'd0, opcode}, 32'd0);
        chk("init_operand", {28'd0, operand}, 32'd0);
        chk("init_halted", {31'd0, halted}, 32'd0);

        // Program run with ready high: valid every third cycle, halt after F0.
        instr_ready = 1'b1;
        push(8'h52, 4'd1);
        push(8'h57, 4'd2);
        push(8'h81, 4'd3);
        push(8'hF0, 4'd4);
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            chk("t1_valid", {31'd0, instr_valid},
                {31'd0, (k == 2 || k == 5 || k == 8 || k == 11)});
            chk("t1_halted", {31'd0, halted}, {31'd0, (k >= 12)});
        end
        chk("t1_pc_frozen", {28'd0, pc_addr}, 32'd4);
        chk("t1_sb_empty", sbq.size(), 32'd0);

        // Stall on 0x57 for five cycles.
        push(8'h52, 4'd1);
        push(8'h57, 4'd2);
        push(8'h81, 4'd3);
        push(8'hF0, 4'd4);
        do_reset();
        tick(4);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t2_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_opcode", {28'd0, opcode}, 32'd5);
            chk("t2_operand", {28'd0, operand}, 32'd7);
            chk("t2_pc", {28'd0, pc_addr}, 32'd2);
        end
        instr_ready = 1'b1;
        tick(10);
        chk("t2_halted", {31'd0, halted}, 32'd1);
        chk("t2_sb_empty", sbq.size(), 32'd0);

        // Branch to 3 while addr 1 is in DATA: 0x57 is never presented.
        push(8'h52, 4'd1);
        push(8'hF0, 4'd4);
        do_reset();
        tick(4);
        branch_en     = 1'b1;
        branch_target = 4'd3;
        tick(1);
        branch_en = 1'b0;
        chk("t3_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("t3_pc_target", {28'd0, pc_addr}, 32'd3);
        tick(2);
        chk("t3_valid", {31'd0, instr_valid}, 32'd1);
        chk("t3_opcode", {28'd0, opcode}, 32'hF);
        tick(1);
        chk("t3_halted", {31'd0, halted}, 32'd1);
        chk("t3_sb_empty", sbq.size(), 32'd0);

        // Branch to 0 in the same cycle as the HALT handshake.
        for (int r = 0; r < 2; r++) begin
            push(8'h52, 4'd1);
            push(8'h57, 4'd2);
            push(8'h81, 4'd3);
            push(8'hF0, 4'd4);
        end
        do_reset();
        tick(11);
        branch_en     = 1'b1;
        branch_target = 4'd0;
        tick(1);
        branch_en = 1'b0;
        chk("t4_halted0", {31'd0, halted}, 32'd0);
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_pc", {28'd0, pc_addr}, 32'd0);
        tick(2);
        chk("t4_refetch_valid", {31'd0, instr_valid}, 32'd1);
        chk("t4_refetch_opc", {28'd0, opcode}, 32'd5);
        chk("t4_refetch_opr", {28'd0, operand}, 32'd2);
        tick(12);
        chk("t4_halted1", {31'd0, halted}, 32'd1);
        chk("t4_sb_empty", sbq.size(), 32'd0);

        // All 0x11: 17 instructions, pc wraps 15 -> 0.
        for (int i = 0; i < 16; i++) rom[i] = 8'h11;
        for (int k = 1; k <= 17; k++) push(8'h11, 4'(k % 16));
        do_reset();
        tick(51);
        instr_ready = 1'b0;
        tick(2);
        chk("t5_valid18", {31'd0, instr_valid}, 32'd1);
        chk("t5_pc18", {28'd0, pc_addr}, 32'd2);
        chk("t5_sb_empty", sbq.size(), 32'd0);

        // Reset while holding an instruction.
        rst    = 1'b1;
        rom[0] = 8'h52;
        tick(1);
        chk("t6_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_pc", {28'd0, pc_addr}, 32'd0);
        chk("t6_opcode", {28'd0, opcode}, 32'd0);
        chk("t6_operand", {28'd0, operand}, 32'd0);
        chk("t6_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        tick(1);
        chk("t6_valid_early", {31'd0, instr_valid}, 32'd0);
        tick(1);
        chk("t6_valid_after", {31'd0, instr_valid}, 32'd1);
        chk("t6_opcode_after", {28'd0, opcode}, 32'd5);
        chk("t6_operand_after", {28'd0, operand}, 32'd2);
        chk("t6_pc_after", {28'd0, pc_addr}, 32'd1);
        chk("t6_sb_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
